// File: rtl/logic_pkg.sv
// Shared constants for the logic-unit leaf blocks.
//   WIDTH : default operand/result width
//   POP_W : width needed to hold a count of 0..WIDTH set bits
//   pop_w : same calculation for an arbitrary width
package logic_pkg;

  localparam int WIDTH = 8;
  localparam int POP_W = $clog2(WIDTH + 1);

  function automatic int pop_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/popcount.sv
// Combinational population count, built as a recursive adder tree.
//   din   : WIDTH-bit input word
//   count : number of 1 bits in din, 0..WIDTH
module popcount
  import logic_pkg::*;
#(
  parameter int WIDTH = logic_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]          din,
  output logic [pop_w(WIDTH)-1:0]   count
);

  localparam int CW = pop_w(WIDTH);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign count = din;
    end else begin : g_split
      // Split into two halves; the high half takes the extra bit when WIDTH is odd.
      localparam int LO_W = WIDTH / 2;
      localparam int HI_W = WIDTH - LO_W;

      logic [pop_w(LO_W)-1:0] cnt_lo;
      logic [pop_w(HI_W)-1:0] cnt_hi;

      popcount #(.WIDTH(LO_W)) u_lo (
        .din   (din[LO_W-1:0]),
        .count (cnt_lo)
      );

      popcount #(.WIDTH(HI_W)) u_hi (
        .din   (din[WIDTH-1:LO_W]),
        .count (cnt_hi)
      );

      assign count = CW'(cnt_lo) + CW'(cnt_hi);
    end
  endgenerate

endmodule

// File: rtl/and_gate_8bit_reg.sv
// Bitwise AND datapath element with a registered copy and result flags.
//   clk    : rising-edge clock for registered outputs
//   rst    : asynchronous active-high reset, clears all registers
//   en     : capture enable
//   a, b   : operands
//   y      : combinational a & b
//   y_q    : registered a & b
//   zero_q : registered "result was all zeros"
//   ones_q : registered "result was all ones"
//   pop_q  : registered count of set bits in the result
module and_gate_8bit_reg
  import logic_pkg::*;
#(
  parameter int WIDTH = logic_pkg::WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  output logic [WIDTH-1:0]          y,
  output logic [WIDTH-1:0]          y_q,
  output logic                      zero_q,
  output logic                      ones_q,
  output logic [pop_w(WIDTH)-1:0]   pop_q
);

  localparam int PW = pop_w(WIDTH);

  logic          zero_d;
  logic          ones_d;
  logic [PW-1:0] pop_d;

  assign y      = a & b;
  assign zero_d = ~|y;
  assign ones_d = &y;

  popcount #(.WIDTH(WIDTH)) u_popcount (
    .din   (y),
    .count (pop_d)
  );

  // zero_q clears to 0 on reset: it means "a captured result was zero",
  // not "nothing captured yet".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= '0;
      zero_q <= 1'b0;
      ones_q <= 1'b0;
      pop_q  <= '0;
    end else if (en) begin
      y_q    <= y;
      zero_q <= zero_d;
      ones_q <= ones_d;
      pop_q  <= pop_d;
    end
  end

endmodule

// File: tb/tb_and_gate_8bit_reg.sv
module tb_and_gate_8bit_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] y;
  logic [7:0] y_q;
  logic       zero_q;
  logic       ones_q;
  logic [3:0] pop_q;

  int total = 0;
  int bad   = 0;

  and_gate_8bit_reg #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .y      (y),
    .y_q    (y_q),
    .zero_q (zero_q),
    .ones_q (ones_q),
    .pop_q  (pop_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] yq;
    logic       z;
    logic       o;
    logic [3:0] p;
  } reg_exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       en;
    logic [7:0] ey;
    reg_exp_t   er;
  } vec_t;

  reg_exp_t sb_q[$];
  reg_exp_t held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input reg_exp_t e);
    chk({tag, " y_q"},    32'(y_q),    32'(e.yq));
    chk({tag, " zero_q"}, 32'(zero_q), 32'(e.z));
    chk({tag, " ones_q"}, 32'(ones_q), 32'(e.o));
    chk({tag, " pop_q"},  32'(pop_q),  32'(e.p));
  endtask

  // Pop the oldest expectation and compare it to the registered outputs.
  task automatic sb_check(input string tag);
    reg_exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk_regs(tag, e);
    end
  endtask

  function automatic reg_exp_t model(input logic [7:0] ra, input logic [7:0] rb);
    reg_exp_t  e;
    logic [7:0] r;
    int        n;
    r = ra & rb;
    n = 0;
    for (int k = 0; k < 8; k++) if (r[k]) n++;
    e.yq = r;
    e.z  = (r == 8'h00);
    e.o  = (r == 8'hFF);
    e.p  = 4'(n);
    return e;
  endfunction

  vec_t vecs[10];
  reg_exp_t zero_regs;

  initial begin
    vecs[0] = '{8'hAA, 8'h00, 1'b1, 8'h00, '{8'h00, 1'b1, 1'b0, 4'd0}};
    vecs[1] = '{8'h00, 8'h00, 1'b1, 8'h00, '{8'h00, 1'b1, 1'b0, 4'd0}};
    vecs[2] = '{8'hAA, 8'hAA, 1'b1, 8'hAA, '{8'hAA, 1'b0, 1'b0, 4'd4}};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, '{8'hFF, 1'b0, 1'b1, 4'd8}};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, '{8'h00, 1'b1, 1'b0, 4'd0}};
    vecs[5] = '{8'hF0, 8'hFF, 1'b0, 8'hF0, '{8'h00, 1'b1, 1'b0, 4'd0}};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'hFF, '{8'h00, 1'b1, 1'b0, 4'd0}};
    vecs[7] = '{8'h0F, 8'h3C, 1'b1, 8'h0C, '{8'h0C, 1'b0, 1'b0, 4'd2}};
    vecs[8] = '{8'h80, 8'h81, 1'b1, 8'h80, '{8'h80, 1'b0, 1'b0, 4'd1}};
    vecs[9] = '{8'hFE, 8'h7F, 1'b1, 8'h7E, '{8'h7E, 1'b0, 1'b0, 4'd6}};
    zero_regs = '{8'h00, 1'b0, 1'b0, 4'd0};

    rst = 1'b1;
    en  = 1'b0;
    a   = 8'h00;
    b   = 8'h00;

    // Reset state, with en high to show reset overrides it.
    #2;
    en = 1'b1;
    a  = 8'hFF;
    b  = 8'hFF;
    @(posedge clk);
    #1;
    chk_regs("reset", zero_regs);
    chk("reset y", 32'(y), 32'h0000_00FF);

    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    // Directed table through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a  = vecs[i].a;
      b  = vecs[i].b;
      en = vecs[i].en;
      #1;
      chk($sformatf("vec%0d y", i), 32'(y), 32'(vecs[i].ey));
      sb_q.push_back(vecs[i].er);
      @(posedge clk);
      #1;
      sb_check($sformatf("vec%0d", i));
    end
    held = vecs[9].er;

    // Random vectors with random enable, checked against the bench model.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(0, 255));
      en = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("rnd%0d y", i), 32'(y), 32'(a & b));
      if (en) held = model(a, b);
      sb_q.push_back(held);
      @(posedge clk);
      #1;
      sb_check($sformatf("rnd%0d", i));
    end

    // Mid-cycle asynchronous reset after loading all ones.
    @(negedge clk);
    a  = 8'hFF;
    b  = 8'hFF;
    en = 1'b1;
    @(posedge clk);
    #1;
    chk_regs("load_ff", '{8'hFF, 1'b0, 1'b1, 4'd8});
    #2;
    rst = 1'b1;
    #1;
    chk_regs("async_rst", zero_regs);
    chk("async_rst y", 32'(y), 32'h0000_00FF);
    a = 8'h3C;
    #1;
    chk("rst y follows", 32'(y), 32'h0000_003C);

    // Reset held across an enabled edge: nothing captured.
    @(posedge clk);
    #1;
    chk_regs("rst_hold", zero_regs);

    // First enabled edge after release captures.
    @(negedge clk);
    rst = 1'b0;
    a   = 8'hFF;
    @(posedge clk);
    #1;
    chk_regs("first_cap", '{8'hFF, 1'b0, 1'b1, 4'd8});

    chk("sb drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $fatal(1);
  end

endmodule
